// File: rtl/timer_sched.sv
// timer_sched: round-robin arbiter that lends the single fabric timer to NCH
// one-shot timeout requesters. It acts as the timer's bus master and runs a
// disable / program / start / wait / read-status / disable sequence for each
// granted request. When the sequence completes it pulses done for that channel.
module timer_sched #(
    parameter int          NCH      = 4,
    parameter logic [31:0] CTRL_RUN = 32'h0000_000B,
    parameter int          IDW      = $clog2(NCH)
) (
    input  logic                 pclk,
    input  logic                 nreset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*32-1:0]    req_len,
    output logic [NCH-1:0]       done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [1:0]           last_status,
    output logic                 tmr_write_en,
    output logic                 tmr_read_en,
    output logic [7:0]           tmr_addr,
    output logic [31:0]          tmr_write_data,
    input  logic [31:0]          tmr_read_data,
    input  logic                 tmr_fabint
);

    // Controller states
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ARB   = 4'd1;
    localparam logic [3:0] S_DIS   = 4'd2;
    localparam logic [3:0] S_WOVF  = 4'd3;
    localparam logic [3:0] S_WCTL  = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_RSTAT = 4'd6;
    localparam logic [3:0] S_RCAP  = 4'd7;
    localparam logic [3:0] S_STOP  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    // Timer register byte addresses
    localparam logic [7:0] A_OVF  = 8'h00;
    localparam logic [7:0] A_CTRL = 8'h08;
    localparam logic [7:0] A_STAT = 8'h10;

    // Extra WAIT cycles tolerated beyond the programmed length before the
    // watchdog declares the timeout complete on its own.
    localparam logic [32:0] WDOG_SLACK = 33'd16;

    logic [3:0]      state_reg, state_next;
    logic [IDW-1:0]  idx_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [31:0]     len_reg;
    logic            cancel_reg;
    logic            wdog_reg;
    logic [32:0]     wait_cnt_reg;
    logic [1:0]      last_status_reg;

    logic [NCH-1:0]  done_reg, done_next;
    logic            busy_reg;
    logic            wr_en_reg, wr_en_next;
    logic            rd_en_reg, rd_en_next;
    logic [7:0]      addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;

    // Only the two status bits of a read are meaningful.
    logic            unused_rd;
    assign unused_rd = ^tmr_read_data[31:2];

    // ------------------------------------------------------------------
    // Rotating arbitration: candidate gi is channel (ptr + gi) mod NCH, and
    // the lowest-numbered candidate with a pending request wins.
    // ------------------------------------------------------------------
    logic [IDW:0]    cand_sum [NCH];
    logic [IDW-1:0]  cand_idx [NCH];
    logic [NCH-1:0]  cand_hit;
    logic [31:0]     len_arr  [NCH];
    logic [IDW-1:0]  pick_idx;
    logic            pick_valid;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(NCH))
                                ? IDW'(cand_sum[gi] - (IDW+1)'(NCH))
                                : cand_sum[gi][IDW-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
            assign len_arr[gi]  = req_len[32*gi +: 32];
        end
    endgenerate

    assign pick_valid = |req;

    // Priority select over the rotated candidates; scanning downward lets the
    // lowest matching offset overwrite all others.
    always_comb begin
        pick_idx = cand_idx[0];
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // WAIT supervision
    // ------------------------------------------------------------------
    logic wdog_hit;
    logic req_cur;

    assign wdog_hit = (wait_cnt_reg >= ({1'b0, len_reg} + WDOG_SLACK));
    assign req_cur  = req[idx_reg];

    // Next-state selection for the sequencing FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pick_valid) state_next = S_ARB;
            S_ARB:   state_next = (len_reg == 32'd0) ? S_DONE : S_DIS;
            S_DIS:   state_next = S_WOVF;
            S_WOVF:  state_next = S_WCTL;
            S_WCTL:  state_next = S_WAIT;
            S_WAIT: begin
                // An interrupt wins over a simultaneous cancel.
                if (tmr_fabint || wdog_hit) begin
                    state_next = S_RSTAT;
                end else if (!req_cur) begin
                    state_next = S_STOP;
                end
            end
            S_RSTAT: state_next = S_RCAP;
            S_RCAP:  state_next = cancel_reg ? S_IDLE : S_STOP;
            // After a cancel, the status is read once more to flush any
            // sticky bit the timer may have latched before being stopped.
            S_STOP:  state_next = cancel_reg ? S_RSTAT : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus access implied by the state being entered, so the strobe is
    // presented from a flop during that state's own cycle.
    always_comb begin
        wr_en_next = 1'b0;
        rd_en_next = 1'b0;
        addr_next  = 8'h00;
        wdata_next = 32'h0;
        case (state_next)
            S_DIS: begin
                wr_en_next = 1'b1;
                addr_next  = A_CTRL;
            end
            S_WOVF: begin
                wr_en_next = 1'b1;
                addr_next  = A_OVF;
                wdata_next = len_reg - 32'd1;
            end
            S_WCTL: begin
                wr_en_next = 1'b1;
                addr_next  = A_CTRL;
                wdata_next = CTRL_RUN;
            end
            S_STOP: begin
                wr_en_next = 1'b1;
                addr_next  = A_CTRL;
            end
            S_RSTAT: begin
                rd_en_next = 1'b1;
                addr_next  = A_STAT;
            end
            default: begin
                wr_en_next = 1'b0;
            end
        endcase
    end

    // One-hot done pulse for the channel being retired
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_done
            assign done_next[gi] = (state_next == S_DONE) && (idx_reg == IDW'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant capture: channel index and its duration are frozen at arbitration
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            idx_reg <= '0;
            len_reg <= 32'h0;
        end else if (state_reg == S_IDLE && pick_valid) begin
            idx_reg <= pick_idx;
            len_reg <= len_arr[pick_idx];
        end
    end

    // Cancel and watchdog flags, cleared per grant and set while waiting
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            cancel_reg <= 1'b0;
            wdog_reg   <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            cancel_reg <= 1'b0;
            wdog_reg   <= 1'b0;
        end else if (state_reg == S_WAIT) begin
            if (!tmr_fabint && wdog_hit) begin
                wdog_reg <= 1'b1;
            end else if (!tmr_fabint && !req_cur) begin
                cancel_reg <= 1'b1;
            end
        end
    end

    // Count cycles spent in WAIT for the watchdog
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            wait_cnt_reg <= 33'h0;
        end else if (state_reg == S_WCTL) begin
            wait_cnt_reg <= 33'h0;
        end else if (state_reg == S_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 33'd1;
        end
    end

    // Capture interrupt status on a real completion; a watchdog completion
    // reports no status bits.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            last_status_reg <= 2'b00;
        end else if (state_reg == S_RCAP && !cancel_reg) begin
            last_status_reg <= wdog_reg ? 2'b00 : tmr_read_data[1:0];
        end
    end

    // Advance the round-robin pointer past the served channel, whether the
    // sequence completed or was cancelled.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            ptr_reg <= '0;
        end else if (state_reg == S_DONE || (state_reg == S_RCAP && cancel_reg)) begin
            ptr_reg <= (idx_reg == IDW'(NCH - 1)) ? '0 : idx_reg + IDW'(1);
        end
    end

    // Registered outputs: bus strobes, done pulses and busy
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            wr_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 32'h0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            wr_en_reg <= wr_en_next;
            rd_en_reg <= rd_en_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            busy_reg  <= (state_next != S_IDLE);
        end
    end

    assign done           = done_reg;
    assign busy           = busy_reg;
    assign grant_id       = idx_reg;
    assign last_status    = last_status_reg;
    assign tmr_write_en   = wr_en_reg;
    assign tmr_read_en    = rd_en_reg;
    assign tmr_addr       = addr_reg;
    assign tmr_write_data = wdata_reg;

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Round-robin scheduler that shares the single fabric timer among NCH one-shot timeout requesters.
- Acts as the timer's bus master. For each granted request it:
  - disables the timer,
  - programs the overflow register,
  - starts the timer with overflow interrupt enabled,
  - waits for fabint,
  - reads and clears the interrupt status,
  - disables the timer, then returns done to the requester.
- Sits between the requester logic and the timer register port.
- Timer register map, byte address:
  - 0x00 overflow; writing it clears the counter.
  - 0x04 value.
  - 0x08 control: bit0 timer enable, bit1 interrupt enable, bit2 compare enable, bit3 overflow enable.
  - 0x0C compare.
  - 0x10 interrupt status; reading it clears it.

Parameters:
- NCH, 4, number of requester channels (2..8).
- CTRL_RUN, 32'h0000000B, control word written to start a timeout: timer enable + interrupt enable + overflow enable.
- IDW, $clog2(NCH), channel index width.

Ports:
- pclk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel timeout request, level; held until done or cancel.
- req_len  in  NCH*32  channel i duration in pclk cycles at bits [32i+31:32i]; sampled at grant.
- done  out  NCH  one-cycle pulse: channel timeout expired.
- busy  out  1  controller not in IDLE.
- grant_id  out  IDW  channel currently served; valid while busy.
- last_status  out  2  interrupt status captured at the last completion.
- tmr_write_en  out  1  timer bus write strobe.
- tmr_read_en  out  1  timer bus read strobe.
- tmr_addr  out  8  timer bus byte address.
- tmr_write_data  out  32  timer bus write data.
- tmr_read_data  in  32  timer bus read data; registered by the timer, valid the cycle after tmr_read_en.
- tmr_fabint  in  1  timer interrupt, one-cycle pulse.

Behaviour:
- Reset:
  - All outputs are 0: done, busy, grant_id, last_status, tmr_write_en, tmr_read_en, tmr_addr, tmr_write_data.
  - State is IDLE.
  - Round-robin pointer is 0, so channel 0 has highest priority first.
  - Asserting reset mid-sequence leaves the timer untouched; the timer's own reset is responsible for it.
- Bus strobes: every access is a single-cycle pulse; tmr_write_en and tmr_read_en are never both high. All bus outputs are registered. tmr_addr and tmr_write_data are 0 when no strobe is active.
- State transitions:
  - IDLE: if any req is set, pick the first set bit searching from ptr upward with wrap-around. Latch idx and len = req_len[idx]; go to ARB.
  - ARB:
    - If len == 0: go to DONE without touching the timer; last_status is unchanged.
    - Otherwise: go to DIS.
  - DIS: write 0 to 0x08, then go to WOVF.
  - WOVF: write len-1 to 0x00, then go to WCTL.
  - WCTL: write CTRL_RUN to 0x08, then go to WAIT.
  - WAIT:
    - If tmr_fabint: go to RSTAT.
    - Else if req[idx] == 0: set cancel flag and go to STOP.
    - tmr_fabint has priority when it coincides with cancel.
  - RSTAT: read 0x10, then go to RCAP.
  - RCAP: sample tmr_read_data[1:0]. If not cancelled, load it into last_status. Then go to STOP, or to IDLE if cancelled.
  - STOP: write 0 to 0x08. Then go to DONE if not cancelled, or to RSTAT if cancelled (clears any stale sticky status).
  - DONE: pulse done[idx]; ptr <= idx+1, modulo NCH; go to IDLE.
- Cancelled sequences do not pulse done, but still advance ptr.
- Timing: with the WCTL write in cycle c, tmr_fabint arrives in cycle c+len+2. The full sequence from IDLE grant to the done pulse takes len+10 cycles.
- Requester contract: drop req in the cycle after done. The controller returns to IDLE and re-arbitrates in that same cycle; a request still high at that point is treated as a new request.
- A req raised mid-sequence on another channel waits until IDLE.
- Spurious tmr_fabint outside WAIT is ignored.
- Watchdog: if WAIT lasts more than len+16 cycles, treat it as a completion. last_status is set to 2'b00 and the sequence proceeds through RSTAT.

Test Plan:
- Reset, then req[1]=1 with len=10 -> bus sequence:
  - write 0x08=0,
  - write 0x00=9,
  - write 0x08=0xB,
  - tmr_fabint 12 cycles after the start write,
  - read 0x10, then write 0x08=0,
  - done[1] pulse; last_status=2'b01, busy=1 throughout and 0 after.
- req=4'b1111 held continuously, all len=3 -> grants in order 0,1,2,3,0; exactly one done pulse per sequence.
- req[2]=1 with len=0 -> done[2] pulses 2 cycles after grant; no tmr_write_en or tmr_read_en asserted.
- req[0] with len=1000, dropped 50 cycles into WAIT -> write 0x08=0, read 0x10, IDLE; done stays 0; ptr advances to 1.
- Cancel and tmr_fabint in the same WAIT cycle -> normal completion; done[0] pulses.
- Reset asserted during WAIT -> all outputs 0 immediately (asynchronous); after release, a new req[3] is granted from channel 0's priority order.
